// File: rtl/tspi_pkg.sv
// Shared types and default widths for the TSPI receive path.
// Word bundle carries the widest supported data plus a last flag.
package tspi_pkg;

  localparam int TspiLenWidth  = 6;
  localparam int TspiCntWidth  = 8;
  localparam int TspiDataWidth = 64;

  typedef enum logic {
    RX_IDLE,
    RX_DATA
  } rx_state_e;

  typedef struct packed {
    logic [TspiDataWidth-1:0] data;
    logic                     last;
  } rx_word_t;

endpackage

// File: rtl/tspi_rx_hold_reg.sv
// Single-entry valid/ready holding register for received words.
// A push into a full, stalled register is dropped and flagged.
module tspi_rx_hold_reg
  import tspi_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_i,
  input  logic     push_i,
  input  rx_word_t word_i,
  input  logic     ready_i,
  input  logic     clr_err_i,
  output rx_word_t word_o,
  output logic     valid_o,
  output logic     overflow_o
);

  rx_word_t r_word;
  logic     r_valid;
  logic     r_ovf;
  logic     w_drop;
  logic     w_load;

  assign w_load = push_i & (~r_valid | ready_i);
  assign w_drop = push_i & r_valid & ~ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_word  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_load) begin
        r_word  <= word_i;
        r_valid <= 1'b1;
      end else if (!push_i && ready_i) begin
        r_valid <= 1'b0;
      end
      // a new drop beats a same-cycle clear
      r_ovf <= w_drop | (r_ovf & ~clr_err_i);
    end
  end

  assign word_o     = r_word;
  assign valid_o    = r_valid;
  assign overflow_o = r_ovf;

endmodule

// File: rtl/tspi_rx_deframer.sv
// TSPI responder deframer: start bit, then cnt words of len+1 bits,
// MSB first, presented through a one-entry valid/ready buffer.
module tspi_rx_deframer
  import tspi_pkg::*;
#(
  parameter int LenWidth  = TspiLenWidth,
  parameter int CntWidth  = TspiCntWidth,
  parameter int DataWidth = TspiDataWidth
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 bit_valid_i,
  input  logic                 sd_i,
  input  logic [LenWidth-1:0]  len_i,
  input  logic [CntWidth-1:0]  cnt_i,
  input  logic                 abort_i,
  output logic [DataWidth-1:0] word_o,
  output logic                 word_valid_o,
  input  logic                 word_ready_i,
  output logic                 last_word_o,
  output logic                 busy_o,
  output logic                 overflow_o,
  output logic                 frame_err_o,
  input  logic                 clr_err_i
);

  rx_state_e            r_state;
  rx_state_e            w_state_nxt;
  logic [LenWidth-1:0]  r_len;
  logic [CntWidth-1:0]  r_rem;
  logic [LenWidth-1:0]  r_bit_cnt;
  logic [DataWidth-1:0] r_shreg;
  logic                 r_ferr;

  logic                 w_load;
  logic                 w_push;
  logic                 w_last;
  logic                 w_ferr_set;
  logic [DataWidth-1:0] w_shift;
  logic [DataWidth-1:0] w_mask;
  rx_word_t             w_push_word;
  rx_word_t             w_hold_word;

  assign w_shift = {r_shreg[DataWidth-2:0], sd_i};
  // two-step shift keeps len = all-ones from overflowing the amount
  assign w_mask  = ~(({DataWidth{1'b1}} << r_len) << 1);

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_push      = 1'b0;
    w_last      = 1'b0;
    w_ferr_set  = 1'b0;
    if (abort_i) begin
      w_state_nxt = RX_IDLE;
    end else begin
      unique case (r_state)
        RX_IDLE: begin
          if (bit_valid_i && sd_i) begin
            w_load = 1'b1;
            if (cnt_i == '0) w_ferr_set = 1'b1;
            else             w_state_nxt = RX_DATA;
          end
        end
        RX_DATA: begin
          if (bit_valid_i && (r_bit_cnt == r_len)) begin
            w_push = 1'b1;
            w_last = (r_rem == CntWidth'(1));
            if (w_last) w_state_nxt = RX_IDLE;
          end
        end
        default: w_state_nxt = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state   <= RX_IDLE;
      r_len     <= '0;
      r_rem     <= '0;
      r_bit_cnt <= '0;
      r_shreg   <= '0;
      r_ferr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ferr  <= w_ferr_set | (r_ferr & ~clr_err_i);
      if (abort_i) begin
        r_bit_cnt <= '0;
        r_rem     <= '0;
      end else if (w_load) begin
        r_len     <= len_i;
        r_rem     <= cnt_i;
        r_bit_cnt <= '0;
        r_shreg   <= '0;
      end else if (r_state == RX_DATA && bit_valid_i) begin
        r_shreg <= w_shift;
        if (w_push) begin
          r_rem     <= r_rem - CntWidth'(1);
          r_bit_cnt <= '0;
        end else begin
          r_bit_cnt <= r_bit_cnt + LenWidth'(1);
        end
      end
    end
  end

  assign w_push_word.data = TspiDataWidth'(w_shift & w_mask);
  assign w_push_word.last = w_last;

  tspi_rx_hold_reg u_hold (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (w_push),
    .word_i     (w_push_word),
    .ready_i    (word_ready_i),
    .clr_err_i  (clr_err_i),
    .word_o     (w_hold_word),
    .valid_o    (word_valid_o),
    .overflow_o (overflow_o)
  );

  assign word_o      = w_hold_word.data[DataWidth-1:0];
  assign last_word_o = w_hold_word.last;
  assign busy_o      = (r_state != RX_IDLE);
  assign frame_err_o = r_ferr;

endmodule

// File: tb/tb_tspi_rx_deframer.sv
// Directed self-checking bench for tspi_rx_deframer.
// Inputs change 1ns after the rising edge; outputs are read there too.
module tb_tspi_rx_deframer;

  logic        clk = 1'b0;
  logic        rst;
  logic        bit_valid;
  logic        sd;
  logic [5:0]  len;
  logic [7:0]  cnt;
  logic        abort;
  logic [63:0] word;
  logic        word_valid;
  logic        word_ready;
  logic        last_word;
  logic        busy;
  logic        overflow;
  logic        frame_err;
  logic        clr_err;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  tspi_rx_deframer dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .bit_valid_i  (bit_valid),
    .sd_i         (sd),
    .len_i        (len),
    .cnt_i        (cnt),
    .abort_i      (abort),
    .word_o       (word),
    .word_valid_o (word_valid),
    .word_ready_i (word_ready),
    .last_word_o  (last_word),
    .busy_o       (busy),
    .overflow_o   (overflow),
    .frame_err_o  (frame_err),
    .clr_err_i    (clr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bit_valid = 1'b1;
    sd = b;
    step();
    bit_valid = 1'b0;
    sd = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] d, input int n);
    for (int i = n - 1; i >= 0; i--) send_bit(d[i]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if ({word, word_valid, last_word, busy, overflow, frame_err} !== 70'd0) begin
      $display("FAIL reset outputs: got word=%h v=%b l=%b b=%b o=%b e=%b want all 0",
               word, word_valid, last_word, busy, overflow, frame_err);
    end else n_pass++;
  endtask

  task automatic test_single();
    word_ready = 1'b1;
    len = 6'd7;
    cnt = 8'd1;
    send_bit(1'b1);
    n_total++;
    if (busy !== 1'b1) $display("FAIL single busy: got %b want 1", busy);
    else n_pass++;
    send_word(64'hA5, 8);
    n_total++;
    if (word_valid !== 1'b1 || word !== 64'hA5 || last_word !== 1'b1)
      $display("FAIL single beat: got v=%b w=%h l=%b want v=1 w=a5 l=1",
               word_valid, word, last_word);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0) $display("FAIL single busy_end: got %b want 0", busy);
    else n_pass++;
    step();
    n_total++;
    if (word_valid !== 1'b0) $display("FAIL single drain: got v=%b want 0", word_valid);
    else n_pass++;
  endtask

  task automatic test_burst();
    word_ready = 1'b1;
    len = 6'd3;
    cnt = 8'd3;
    send_bit(1'b1);
    for (int w = 1; w <= 3; w++) begin
      send_word(64'(w), 4);
      n_total++;
      if (word_valid !== 1'b1 || word !== 64'(w) || last_word !== (w == 3))
        $display("FAIL burst beat%0d: got v=%b w=%h l=%b want v=1 w=%0d l=%b",
                 w, word_valid, word, last_word, w, (w == 3));
      else n_pass++;
    end
    n_total++;
    if (busy !== 1'b0) $display("FAIL burst busy_end: got %b want 0", busy);
    else n_pass++;
    step();
  endtask

  task automatic test_backpressure();
    word_ready = 1'b0;
    len = 6'd3;
    cnt = 8'd2;
    send_bit(1'b1);
    send_word(64'h1, 4);
    n_total++;
    if (word_valid !== 1'b1 || word !== 64'h1 || overflow !== 1'b0)
      $display("FAIL bp first: got v=%b w=%h o=%b want v=1 w=1 o=0",
               word_valid, word, overflow);
    else n_pass++;
    send_word(64'h2, 4);
    n_total++;
    if (word_valid !== 1'b1 || word !== 64'h1 || overflow !== 1'b1 || busy !== 1'b0)
      $display("FAIL bp second: got v=%b w=%h o=%b b=%b want v=1 w=1 o=1 b=0",
               word_valid, word, overflow, busy);
    else n_pass++;
    step();
    n_total++;
    if (overflow !== 1'b1) $display("FAIL bp sticky: got %b want 1", overflow);
    else n_pass++;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    n_total++;
    if (overflow !== 1'b0) $display("FAIL bp clear: got %b want 0", overflow);
    else n_pass++;
    word_ready = 1'b1;
    step();
    n_total++;
    if (word_valid !== 1'b0) $display("FAIL bp drain: got v=%b want 0", word_valid);
    else n_pass++;
  endtask

  task automatic test_max_len();
    word_ready = 1'b1;
    len = 6'd63;
    cnt = 8'd1;
    send_bit(1'b1);
    for (int i = 0; i < 64; i++) send_bit((i % 2) == 0);
    n_total++;
    if (word_valid !== 1'b1 || word !== 64'hAAAA_AAAA_AAAA_AAAA || last_word !== 1'b1)
      $display("FAIL maxlen beat: got v=%b w=%h l=%b want v=1 w=aaaaaaaaaaaaaaaa l=1",
               word_valid, word, last_word);
    else n_pass++;
    step();
  endtask

  task automatic test_abort();
    word_ready = 1'b1;
    len = 6'd7;
    cnt = 8'd2;
    send_bit(1'b1);
    send_word(64'h5, 3);
    abort = 1'b1;
    send_bit(1'b1);
    abort = 1'b0;
    n_total++;
    if (busy !== 1'b0 || word_valid !== 1'b0)
      $display("FAIL abort state: got b=%b v=%b want b=0 v=0", busy, word_valid);
    else n_pass++;
    cnt = 8'd1;
    send_bit(1'b1);
    send_word(64'h3C, 8);
    n_total++;
    if (word_valid !== 1'b1 || word !== 64'h3C || last_word !== 1'b1)
      $display("FAIL abort refr: got v=%b w=%h l=%b want v=1 w=3c l=1",
               word_valid, word, last_word);
    else n_pass++;
    step();
  endtask

  task automatic test_errors();
    len = 6'd3;
    cnt = 8'd0;
    send_bit(1'b1);
    n_total++;
    if (frame_err !== 1'b1 || busy !== 1'b0)
      $display("FAIL err cnt0: got e=%b b=%b want e=1 b=0", frame_err, busy);
    else n_pass++;
    clr_err = 1'b1;
    send_bit(1'b1);
    n_total++;
    if (frame_err !== 1'b1) $display("FAIL err setwins: got %b want 1", frame_err);
    else n_pass++;
    step();
    clr_err = 1'b0;
    n_total++;
    if (frame_err !== 1'b0) $display("FAIL err clear: got %b want 0", frame_err);
    else n_pass++;
    word_ready = 1'b0;
    cnt = 8'd2;
    send_bit(1'b1);
    send_word(64'h9, 4);
    send_word(64'h2, 2);
    n_total++;
    if (word_valid !== 1'b1 || busy !== 1'b1)
      $display("FAIL err midframe: got v=%b b=%b want v=1 b=1", word_valid, busy);
    else n_pass++;
    do_reset();
    n_total++;
    if ({word, word_valid, last_word, busy, overflow, frame_err} !== 70'd0)
      $display("FAIL err reset: got w=%h v=%b l=%b b=%b o=%b e=%b want all 0",
               word, word_valid, last_word, busy, overflow, frame_err);
    else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bit_valid = 1'b0;
    sd = 1'b0;
    len = '0;
    cnt = '0;
    abort = 1'b0;
    word_ready = 1'b0;
    clr_err = 1'b0;
    #1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_max_len();
    test_abort();
    test_errors();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/tspi_rx_deframer.md
Name: tspi_rx_deframer

Overview:
- Receive-side counterpart of the TSPI transmit command counter: deserialises TSPI frames in the responder.
- Detects the start bit and shifts in `len+1` data bits per word, MSB first.
- Repeats for `cnt` back-to-back words, then returns to idle.
- Presents each word on a valid/ready interface; a one-entry holding register provides buffering.

Parameters:
- LenWidth, 6, width of the per-word length field; bits per word = len_i+1, max 2^LenWidth.
- CntWidth, 8, width of the word-count field.
- DataWidth, 64, output word width; must be >= 2^LenWidth.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  reset; reset is synchronous and active-high.
- bit_valid_i  in  1  one-cycle strobe: sd_i holds a valid line sample this cycle.
- sd_i  in  1  serial data line; idles low.
- len_i  in  LenWidth  bits-per-word minus one, latched at start bit.
- cnt_i  in  CntWidth  words per frame, latched at start bit.
- abort_i  in  1  synchronous frame abort.
- word_o  out  DataWidth  received word, right-aligned, zero-extended.
- word_valid_o  out  1  word_o valid.
- word_ready_i  in  1  consumer accepts word_o.
- last_word_o  out  1  qualifies word_o: final word of its frame.
- busy_o  out  1  frame in progress (state != IDLE).
- overflow_o  out  1  sticky: a completed word was dropped.
- frame_err_o  out  1  sticky: start bit seen with cnt_i==0.
- clr_err_i  in  1  clears overflow_o and frame_err_o.

Behaviour:
- Reset: state IDLE. All outputs 0. Shift register, bit counter and remaining-word counter are 0.
- IDLE:
  - bit_valid_i & sd_i==1 is the start bit.
  - Latch len_q=len_i and rem_q=cnt_i; clear bit_cnt and the shift register.
  - If cnt_i==0: set frame_err_o and stay in IDLE. Otherwise go to DATA.
  - Samples with sd_i==0 are ignored.
- DATA: on each bit_valid_i:
  - shreg <= {shreg[DataWidth-2:0], sd_i}.
  - If bit_cnt==len_q, the word is complete:
    - push {shreg, sd_i} masked to len_q+1 bits, with last=(rem_q==1);
    - rem_q <= rem_q-1 and bit_cnt <= 0;
    - if rem_q==1, go to IDLE; otherwise stay in DATA. There is no start bit between words of a frame.
  - Otherwise bit_cnt <= bit_cnt+1.
  - No bit_valid_i means hold.
- Latency: word_valid_o rises the cycle after the strobe carrying the last data bit.
- Holding register handshake:
  - Transfer occurs when word_valid_o & word_ready_i.
  - word_o and last_word_o stay stable while valid & !ready.
  - Push with the register empty, or full and ready the same cycle: load the new word; valid=1.
  - Push with the register full and !ready: drop the new word, keep the old one, set overflow_o. Counters still advance.
  - Ready without push: valid <= 0.
- abort_i:
  - Highest priority over bit_valid_i in the same cycle.
  - Forces IDLE and clears bit_cnt and rem_q.
  - Does not touch the holding register or sticky flags.
  - A partial word is discarded without error.
- Sticky flags:
  - clr_err_i clears both flags.
  - A set event in the same cycle as clr_err_i wins; the flag reads 1.
- Reset mid-frame returns to IDLE and discards the held word.
- Width rules:
  - bit_cnt is LenWidth wide; len_i = all-ones gives 2^LenWidth bits.
  - rem_q is CntWidth wide and never wraps, because the decrement only occurs when rem_q >= 1.
- Start bit while in DATA is treated as data; no resynchronisation.

Decomposition:
- tspi_pkg:
  - rx_state_e enum {RX_IDLE, RX_DATA};
  - default width constants TspiLenWidth=6 and TspiCntWidth=8;
  - struct rx_word_t {data, last}.
- One natural sub-module: tspi_rx_hold_reg, the single-entry valid/ready buffer with overflow detect.
- Shift and counting logic stay in the top level.

Test Plan:
- Single word: len_i=7, cnt_i=1; start bit then bits 1010_0101 with ready=1 -> one beat: word_o=0xA5, last_word_o=1, busy_o low the cycle after.
- Burst: len_i=3, cnt_i=3; nibbles 0x1, 0x2, 0x3 back-to-back with no intermediate start bits -> three beats 0x1/0x2/0x3; last_word_o set only on 0x3.
- Backpressure: len_i=3, cnt_i=2, word_ready_i=0 throughout -> word_o holds 0x1 and overflow_o=1 after the second word; clr_err_i -> overflow_o=0.
- Max length: len_i=63, cnt_i=1, 64 alternating bits starting 1 -> word_o=0xAAAA_AAAA_AAAA_AAAA.
- Abort: len_i=7, cnt_i=2; abort_i asserted together with the 4th data bit strobe -> no output beat, busy_o=0 next cycle. A following frame with cnt_i=1, data 0x3C -> word_o=0x3C.
- Error/reset: start bit with cnt_i=0 -> frame_err_o=1, busy_o=0. rst_i mid-frame -> all outputs 0 the next cycle.
